// File: rtl/smul_pkg.sv
// rtl/smul_pkg.sv - mode/state encodings and parameter checks for the sparse column multiplier
package smul_pkg;

    localparam logic [1:0] MODE_MUL    = 2'b00;
    localparam logic [1:0] MODE_MULH   = 2'b01;
    localparam logic [1:0] MODE_MULHSU = 2'b10;
    localparam logic [1:0] MODE_MULHU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic bit cols_legal(input int cols);
        return (cols == 1) || (cols == 2) || (cols == 4);
    endfunction

endpackage

// File: rtl/smul_lsb_pick.sv
// rtl/smul_lsb_pick.sv - picks up to COLS_PER_CYCLE lowest set bits of a mask and clears them
module smul_lsb_pick #(
    parameter int DATA_W         = 32,
    parameter int COLS_PER_CYCLE = 1,
    localparam int IDX_W         = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]                     mask_i,
    output logic [COLS_PER_CYCLE-1:0][IDX_W-1:0]  idx_o,
    output logic [COLS_PER_CYCLE-1:0]             vld_o,
    output logic [DATA_W-1:0]                     mask_o
);

    always_comb begin
        logic [DATA_W-1:0] m;
        m      = mask_i;
        idx_o  = '0;
        vld_o  = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            vld_o[k] = |m;
            // Scan downward so the lowest set bit is the last one written.
            for (int i = DATA_W - 1; i >= 0; i--) begin
                if (m[i]) begin
                    idx_o[k] = IDX_W'(i);
                end
            end
            m = m & (m - DATA_W'(1));
        end
        mask_o = m;
    end

endmodule

// File: rtl/sparse_column_multiplier.sv
// rtl/sparse_column_multiplier.sv - RV32M sequential multiplier skipping zero columns
// Optional CBM_OPERAND_SWAP_EN: the operand with fewer set bits drives the columns.
module sparse_column_multiplier
    import smul_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int COLS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int ACC_W = 2 * DATA_W;

    if (!cols_legal(COLS_PER_CYCLE)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              neg_q, neg_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              accept;
    logic              a_sgn, b_sgn;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W-1:0] mask_init, mcand_init;

    logic [COLS_PER_CYCLE-1:0][IDX_W-1:0] pick_idx;
    logic [COLS_PER_CYCLE-1:0]            pick_vld;
    logic [DATA_W-1:0]                    pick_mask;
    logic [ACC_W-1:0]                     acc_sum;
    logic [ACC_W-1:0]                     prod;

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign busy_o   = (state_q == ST_RUN);
    assign result_o = result_q;
    assign tag_o    = tag_q;
    assign accept   = valid_i & ready_o & ~flush_i;

    assign a_sgn = ((mode_i == MODE_MULH) || (mode_i == MODE_MULHSU)) & op_a_i[DATA_W-1];
    assign b_sgn = (mode_i == MODE_MULH) & op_b_i[DATA_W-1];
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign abs_a = a_sgn ? (DATA_W'(0) - op_a_i) : op_a_i;
    assign abs_b = b_sgn ? (DATA_W'(0) - op_b_i) : op_b_i;

`ifdef CBM_OPERAND_SWAP_EN
    function automatic int unsigned popcnt(input logic [DATA_W-1:0] v);
        popcnt = 0;
        for (int i = 0; i < DATA_W; i++) begin
            popcnt += 32'(v[i]);
        end
    endfunction

    logic swap;
    assign swap       = popcnt(abs_b) < popcnt(abs_a);
    assign mask_init  = swap ? abs_b : abs_a;
    assign mcand_init = swap ? abs_a : abs_b;
`else
    assign mask_init  = abs_a;
    assign mcand_init = abs_b;
`endif

    smul_lsb_pick #(
        .DATA_W         (DATA_W),
        .COLS_PER_CYCLE (COLS_PER_CYCLE)
    ) u_pick (
        .mask_i (mask_q),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld),
        .mask_o (pick_mask)
    );

    always_comb begin
        acc_sum = acc_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            if (pick_vld[k]) begin
                acc_sum = acc_sum + (mcand_q << pick_idx[k]);
            end
        end
        prod = neg_q ? (ACC_W'(0) - acc_sum) : acc_sum;
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        neg_d    = neg_q;
        tag_d    = tag_q;
        acc_d    = acc_q;
        mask_d   = mask_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d  = mode_i;
                    neg_d   = a_sgn ^ b_sgn;
                    tag_d   = tag_i;
                    acc_d   = '0;
                    mask_d  = mask_init;
                    mcand_d = {{DATA_W{1'b0}}, mcand_init};
                    if (mask_init == '0) begin
                        state_d  = ST_DONE;
                        result_d = '0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_d  = acc_sum;
                mask_d = pick_mask;
                if (pick_mask == '0) begin
                    state_d  = ST_DONE;
                    result_d = (mode_q == MODE_MUL) ? prod[DATA_W-1:0] : prod[ACC_W-1:DATA_W];
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            neg_q    <= 1'b0;
            tag_q    <= '0;
            acc_q    <= '0;
            mask_q   <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            neg_q    <= neg_d;
            tag_q    <= tag_d;
            acc_q    <= acc_d;
            mask_q   <= mask_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_sparse_column_multiplier.sv
// tb/tb_sparse_column_multiplier.sv - directed self-checking bench for sparse_column_multiplier
module tb_sparse_column_multiplier;

    logic        clk, rst, flush, valid, ready_in;
    logic [1:0]  mode;
    logic [31:0] op_a, op_b;
    logic [4:0]  tag;
    logic        r1, v1, busy1, r4, v4, busy4;
    logic [31:0] res1, res4;
    logic [4:0]  tago1, tago4;
    int          checks = 0;
    int          failures = 0;

    sparse_column_multiplier #(.DATA_W(32), .COLS_PER_CYCLE(1), .TAG_W(5)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(r1),
        .mode_i(mode), .op_a_i(op_a), .op_b_i(op_b), .tag_i(tag), .valid_o(v1),
        .ready_i(ready_in), .result_o(res1), .tag_o(tago1), .busy_o(busy1));

    sparse_column_multiplier #(.DATA_W(32), .COLS_PER_CYCLE(4), .TAG_W(5)) dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(r4),
        .mode_i(mode), .op_a_i(op_a), .op_b_i(op_b), .tag_i(tag), .valid_o(v4),
        .ready_i(ready_in), .result_o(res4), .tag_o(tago4), .busy_o(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op to both instances with ready_i high; report latency (0 = never) and results.
    task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, output int lat1, output int lat4,
                          output logic [31:0] o1, output logic [31:0] o4, output logic [4:0] ot1);
        int c;
        mode = m; op_a = a; op_b = b; tag = t; valid = 1'b1;
        step();
        valid = 1'b0;
        lat1 = 0; lat4 = 0; o1 = 'x; o4 = 'x; ot1 = 'x; c = 1;
        while ((lat1 == 0 || lat4 == 0) && c <= 100) begin
            if (v1 && lat1 == 0) begin lat1 = c; o1 = res1; ot1 = tago1; end
            if (v4 && lat4 == 0) begin lat4 = c; o4 = res4; end
            if (lat1 == 0 || lat4 == 0) begin step(); c++; end
        end
        step();
    endtask

    task automatic test_reset();
        checks++;
        if (r1 !== 1'b1 || v1 !== 1'b0 || busy1 !== 1'b0 || res1 !== 32'h0 || tago1 !== 5'h0) begin
            failures++;
            $display("FAIL reset_k1 got r=%b v=%b b=%b res=%h tag=%h exp 1 0 0 0 0", r1, v1, busy1, res1, tago1);
        end
        checks++;
        if (r4 !== 1'b1 || v4 !== 1'b0 || busy4 !== 1'b0 || res4 !== 32'h0 || tago4 !== 5'h0) begin
            failures++;
            $display("FAIL reset_k4 got r=%b v=%b b=%b res=%h tag=%h exp 1 0 0 0 0", r4, v4, busy4, res4, tago4);
        end
    endtask

    task automatic test_mul_basic();
        int l1, l4; logic [31:0] o1, o4; logic [4:0] t1;
        run_op(2'b00, 32'd5, 32'd7, 5'h15, l1, l4, o1, o4, t1);
        checks++; if (l1 !== 3) begin failures++; $display("FAIL mul_lat_k1 got=%0d exp=3", l1); end
        checks++; if (l4 !== 2) begin failures++; $display("FAIL mul_lat_k4 got=%0d exp=2", l4); end
        checks++; if (o1 !== 32'd35) begin failures++; $display("FAIL mul_res_k1 got=%h exp=%h", o1, 32'd35); end
        checks++; if (o4 !== 32'd35) begin failures++; $display("FAIL mul_res_k4 got=%h exp=%h", o4, 32'd35); end
        checks++; if (t1 !== 5'h15) begin failures++; $display("FAIL mul_tag got=%h exp=15", t1); end
    endtask

    task automatic test_signed();
        int l1, l4; logic [31:0] o1, o4; logic [4:0] t1;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 5'h01, l1, l4, o1, o4, t1);
        checks++; if (o1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulh_neg got=%h exp=ffffffff", o1); end
        checks++; if (l1 !== 3) begin failures++; $display("FAIL mulh_neg_lat got=%0d exp=3", l1); end
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 5'h02, l1, l4, o1, o4, t1);
        checks++; if (o1 !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mul_neg_k1 got=%h exp=fffffff1", o1); end
        checks++; if (o4 !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mul_neg_k4 got=%h exp=fffffff1", o4); end
    endtask

    task automatic test_extremes();
        int l1, l4; logic [31:0] o1, o4; logic [4:0] t1;
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, l1, l4, o1, o4, t1);
        checks++; if (o1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_max got=%h exp=fffffffe", o1); end
        checks++; if (o4 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_max_k4 got=%h exp=fffffffe", o4); end
        checks++; if (l1 !== 33) begin failures++; $display("FAIL mulhu_lat_k1 got=%0d exp=33", l1); end
        checks++; if (l4 !== 9) begin failures++; $display("FAIL mulhu_lat_k4 got=%0d exp=9", l4); end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'h04, l1, l4, o1, o4, t1);
        checks++; if (o1 !== 32'h4000_0000) begin failures++; $display("FAIL mulh_minneg got=%h exp=40000000", o1); end
        checks++; if (l1 !== 2) begin failures++; $display("FAIL mulh_minneg_lat got=%0d exp=2", l1); end
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, l1, l4, o1, o4, t1);
        checks++; if (o1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", o1); end
    endtask

    task automatic test_zero_and_wide();
        int l1, l4; logic [31:0] o1, o4; logic [4:0] t1;
        run_op(2'b00, 32'h0, 32'h1234, 5'h06, l1, l4, o1, o4, t1);
        checks++; if (l1 !== 1 || l4 !== 1) begin failures++; $display("FAIL zero_lat got=%0d/%0d exp=1/1", l1, l4); end
        checks++; if (o1 !== 32'h0) begin failures++; $display("FAIL zero_res got=%h exp=0", o1); end
        run_op(2'b00, 32'hFF, 32'h3FF, 5'h07, l1, l4, o1, o4, t1);
        checks++; if (l4 !== 3) begin failures++; $display("FAIL wide_lat_k4 got=%0d exp=3", l4); end
        checks++; if (l1 !== 9) begin failures++; $display("FAIL wide_lat_k1 got=%0d exp=9", l1); end
        checks++; if (o4 !== 32'h3FB01) begin failures++; $display("FAIL wide_res_k4 got=%h exp=3fb01", o4); end
    endtask

    task automatic test_backpressure();
        int c;
        ready_in = 1'b0;
        mode = 2'b00; op_a = 32'd5; op_b = 32'd7; tag = 5'h0A; valid = 1'b1;
        step();
        valid = 1'b0;
        c = 0;
        while (!v1 && c < 50) begin step(); c++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (v1 !== 1'b1 || res1 !== 32'd35 || tago1 !== 5'h0A || r1 !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d got v=%b res=%h tag=%h rdy=%b exp 1 23 0a 0", i, v1, res1, tago1, r1);
            end
            step();
        end
        ready_in = 1'b1;
        step();
        checks++;
        if (r1 !== 1'b1 || v1 !== 1'b0) begin
            failures++; $display("FAIL release got rdy=%b v=%b exp 1 0", r1, v1);
        end
        step();
    endtask

    task automatic test_flush();
        int seen;
        mode = 2'b00; op_a = 32'hFF; op_b = 32'hFFFF; tag = 5'h0B; valid = 1'b1;
        step();
        valid = 1'b0;
        step(); step();
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%b exp=1", busy1); end
        flush = 1'b1; valid = 1'b1; op_a = 32'd1; op_b = 32'd1;
        step();
        flush = 1'b0; valid = 1'b0;
        checks++;
        if (r1 !== 1'b1 || v1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++; $display("FAIL flush_idle got rdy=%b v=%b busy=%b exp 1 0 0", r1, v1, busy1);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (v1 || v4 || busy1) seen++;
            step();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        mode = 2'b00; op_a = 32'hFF; op_b = 32'hFFFF; tag = 5'h0C; valid = 1'b1;
        step();
        valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (r1 !== 1'b1 || v1 !== 1'b0 || busy1 !== 1'b0 || res1 !== 32'h0 || tago1 !== 5'h0) begin
            failures++;
            $display("FAIL rst_mid got r=%b v=%b b=%b res=%h tag=%h exp 1 0 0 0 0", r1, v1, busy1, res1, tago1);
        end
        #3 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (v1 || busy1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rst_quiet got=%0d exp=0", seen); end
    endtask

`ifdef CBM_OPERAND_SWAP_EN
    task automatic test_swap();
        int l1, l4; logic [31:0] o1, o4; logic [4:0] t1;
        run_op(2'b00, 32'hFFFF, 32'd3, 5'h0D, l1, l4, o1, o4, t1);
        checks++; if (l1 !== 3) begin failures++; $display("FAIL swap_lat got=%0d exp=3", l1); end
        checks++; if (o1 !== 32'h2FFFD) begin failures++; $display("FAIL swap_res got=%h exp=2fffd", o1); end
        checks++; if (l4 !== 2) begin failures++; $display("FAIL swap_lat_k4 got=%0d exp=2", l4); end
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
        mode = 2'b00; op_a = '0; op_b = '0; tag = '0;
        #2;
        test_reset();
        #10 rst = 1'b0;
        step();
        test_mul_basic();
        test_signed();
        test_extremes();
        test_zero_and_wide();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
`ifdef CBM_OPERAND_SWAP_EN
        test_swap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
